stopwatch_timer: RTL and testbench
==================================

# stopwatch_timer

Parametrised BCD stopwatch/countdown timer with integrated active-low seven-segment decode, successor to the fixed two-digit seconds counter on the lab board. It divides the system clock into a configurable tick and counts DIGITS decimal digits, either up with wrap-around or down from a loaded value to zero. It adds explicit run/pause state, synchronous load, terminal/wrap pulses and an optional lap-freeze display. It sits between the board push-buttons/switches and the HEX display pins.

## Interface
- TICK_DIV, default 50_000_000: system clocks per count tick, ≥2.
- DIGITS, default 2: number of BCD digits, 1–6.
- clk  in  1  system clock, all state on rising edge.
- clr_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear, highest synchronous priority.
- load  in  1  synchronous load of load_val.
- load_val  in  4*DIGITS  BCD preload, digit 0 in [3:0].
- run  in  1  level; 1 = count, 0 = pause.
- mode  in  1  0 = count up, 1 = count down.
- lap  in  1  single-cycle lap pulse (only with LAP_HOLD_EN).
- count_bcd  out  4*DIGITS  live BCD count.
- hex  out  7*DIGITS  active-low segments of displayed value, digit 0 in [6:0], bit 6 = g.
- tick  out  1  one-cycle pulse on every count update.
- wrap  out  1  one-cycle pulse when up count wraps all-9s to 0.
- done  out  1  one-cycle pulse when down count reaches 0.
- running  out  1  high while state is RUN.

## Operation
- States: IDLE, RUN, PAUSE, DONE. clr_n low: state IDLE, count 0, divider 0, tick/wrap/done 0, running 0, lap freeze off, hex all digits 7'h40.
- Synchronous priority per cycle: clear > load > state machine.
- clear: count 0, divider 0, state IDLE, freeze off.
- load: count = load_val with any digit >9 clamped to 9, divider 0, state IDLE, freeze off.
- IDLE: run=1 → RUN, mode latched into internal direction; except direction down with count 0 → stay IDLE.
- RUN: run=0 → PAUSE (divider held). Otherwise divider increments; at TICK_DIV-1 divider → 0 and count steps by one in latched direction with BCD carry/borrow per digit.
- PAUSE: run=1 → RUN, divider resumes from held value; mode not re-latched.
- Up: all-9s → 0, wrap pulses, stays RUN.
- Down: step reaching 0 → DONE, done pulses. DONE ignores run; leaves only via clear, load or reset.
- Segment codes 0–9: 40,79,24,30,19,12,02,78,00,10 (hex). No blanking of leading zeros.

## Timing
- Count, tick, wrap, done all update on the same edge at which divider equals TICK_DIV-1 in RUN; first tick after entering RUN from IDLE arrives TICK_DIV cycles after the RUN-entry edge.
- hex is combinational from the displayed value (zero added latency).
- running asserts on the edge entering RUN, deasserts on the edge leaving it.
- run dropping in the same cycle as a terminal divider value: pause wins, no step, divider holds TICK_DIV-1; step occurs on first RUN cycle after resume.
- clear/load coincident with a tick: clear/load wins, no pulse emitted.
- Reset assertion mid-count takes effect immediately, independent of clk.

## Configuration
- LAP_HOLD_EN defined: lap pulse in RUN or PAUSE toggles freeze; while frozen, hex shows snapshot of count_bcd taken on the freezing edge and count continues internally; clear, load, reset or entering DONE release freeze.
- LAP_HOLD_EN undefined: lap ignored, no snapshot register, hex always decodes count_bcd.

## Test plan
- Reset: TICK_DIV=4, DIGITS=2, clr_n low then high → count_bcd 8'h00, hex 14'h2040, all pulses 0, running 0.
- Up wrap: load 8'h98, mode 0, run 1 → tick every 4 cycles, counts 99, 00 with wrap single pulse at 00, state RUN.
- Down done: load 8'h02, mode 1, run 1 → 01, 00 after 8 cycles, done one pulse, running 0, further run ignored; load 8'h10 → 09 next tick after run.
- Pause: running up, drop run 2 cycles after a tick for 10 cycles → count unchanged, resume gives next tick exactly 2 cycles after run re-asserted.
- Priority: assert clear and load same cycle as tick with load_val 8'h5F → count 00, no tick; then load alone → 8'h59 clamp.
- Lap (LAP_HOLD_EN): lap at count 12, wait 3 ticks → hex shows 12 while count_bcd 15; second lap → hex shows 15.

Source files
------------

// File: rtl/stopwatch_timer_if.sv
// stopwatch_timer_if: control inputs and display/status outputs of the stopwatch timer.
interface stopwatch_timer_if #(parameter int DIGITS = 2);
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  run;
    logic                  mode;
    logic                  lap;
    logic [4*DIGITS-1:0]   count_bcd;
    logic [7*DIGITS-1:0]   hex;
    logic                  tick;
    logic                  wrap;
    logic                  done;
    logic                  running;
    modport master (
        output clear, load, load_val, run, mode, lap,
        input  count_bcd, hex, tick, wrap, done, running
    );
    modport slave (
        input  clear, load, load_val, run, mode, lap,
        output count_bcd, hex, tick, wrap, done, running
    );
endinterface

// File: rtl/stopwatch_timer.sv
// stopwatch_timer: BCD up/down stopwatch with tick divider and active-low 7-segment decode.
// Optional lap-freeze display enabled by defining LAP_HOLD_EN.
module stopwatch_timer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int DIGITS   = 2
) (
    input logic              clk,
    input logic              clr_n,
    stopwatch_timer_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
    localparam logic [W-1:0]  NINES   = {DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t         state, state_n;
    logic [W-1:0]   cnt, cnt_n, disp;
    logic [DW-1:0]  div, div_n;
    logic           dir, dir_n;
    logic           tick_r, tick_n, wrap_r, wrap_n, done_r, done_n;

    function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic down);
        logic [W-1:0] r;
        logic         c;
        logic [3:0]   d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                r[4*i +: 4] = down ? (d == 4'd0 ? 4'd9 : d - 4'd1) : (d == 4'd9 ? 4'd0 : d + 4'd1);
                c = down ? (d == 4'd0) : (d == 4'd9);
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++)
            r[4*i +: 4] = v[4*i +: 4] > 4'd9 ? 4'd9 : v[4*i +: 4];
        return r;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        div_n   = div;
        dir_n   = dir;
        tick_n  = 1'b0;
        wrap_n  = 1'b0;
        done_n  = 1'b0;
        if (bus.clear) begin
            state_n = IDLE;
            cnt_n   = '0;
            div_n   = '0;
        end else if (bus.load) begin
            state_n = IDLE;
            cnt_n   = bcd_clamp(bus.load_val);
            div_n   = '0;
        end else begin
            case (state)
                IDLE: if (bus.run && !(bus.mode && cnt == '0)) begin
                    state_n = RUN;
                    dir_n   = bus.mode;
                end
                // Pause takes precedence over a terminal divider value, so the step waits for resume.
                RUN: if (!bus.run) begin
                    state_n = PAUSE;
                end else if (div == DIV_MAX) begin
                    div_n  = '0;
                    cnt_n  = bcd_step(cnt, dir);
                    tick_n = 1'b1;
                    wrap_n = !dir && cnt == NINES;
                    if (dir && cnt_n == '0) begin
                        done_n  = 1'b1;
                        state_n = DONE;
                    end
                end else begin
                    div_n = div + 1'b1;
                end
                PAUSE: if (bus.run) state_n = RUN;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= IDLE;
            cnt    <= '0;
            div    <= '0;
            dir    <= 1'b0;
            tick_r <= 1'b0;
            wrap_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            div    <= div_n;
            dir    <= dir_n;
            tick_r <= tick_n;
            wrap_r <= wrap_n;
            done_r <= done_n;
        end
    end

`ifdef LAP_HOLD_EN
    logic         frozen, frozen_n, lap_ok;
    logic [W-1:0] snap, snap_n;

    always_comb begin
        lap_ok   = bus.lap && (state == RUN || state == PAUSE);
        frozen_n = (bus.clear || bus.load || state_n == DONE) ? 1'b0 : (lap_ok ? !frozen : frozen);
        snap_n   = (lap_ok && !frozen) ? cnt : snap;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            frozen <= 1'b0;
            snap   <= '0;
        end else begin
            frozen <= frozen_n;
            snap   <= snap_n;
        end
    end

    assign disp = frozen ? snap : cnt;
`else
    assign disp = cnt;
`endif

    genvar g;
    for (g = 0; g < DIGITS; g++) begin : gen_hex
        assign bus.hex[7*g +: 7] = seg(disp[4*g +: 4]);
    end

    assign bus.count_bcd = cnt;
    assign bus.tick      = tick_r;
    assign bus.wrap      = wrap_r;
    assign bus.done      = done_r;
    assign bus.running   = state == RUN;
endmodule

// File: tb/tb_stopwatch_timer.sv
// tb_stopwatch_timer: vector table, corner sequences and randomized run against an integer-arithmetic model.
module tb_stopwatch_timer;
    localparam int TD  = 4;
    localparam int ND  = 2;
    localparam int MOD = 100;
    localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    stopwatch_timer_if #(.DIGITS(ND)) bus ();
    stopwatch_timer #(.TICK_DIV(TD), .DIGITS(ND)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));

    typedef struct {
        logic       clear, load;
        logic [7:0] lv;
        logic       run, mode;
        logic [7:0] cnt;
        logic       tick, wrap, done, running;
    } vec_t;

    int n_chk = 0, n_fail = 0;
    int m_val, m_acc, m_snap;
    bit m_go, m_hold, m_fin, m_down, m_frz, m_tick, m_wrap, m_done;

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r;
        int p = 1;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [7*ND-1:0] to_hex(input int v);
        logic [7*ND-1:0] r;
        int p = 1;
        for (int i = 0; i < ND; i++) begin
            r[7*i +: 7] = SEG[(v / p) % 10];
            p *= 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [4*ND-1:0] lv);
        int v = 0, p = 1, d;
        for (int i = 0; i < ND; i++) begin
            d = int'(lv[4*i +: 4]);
            v += (d > 9 ? 9 : d) * p;
            p *= 10;
        end
        return v;
    endfunction

    function automatic vec_t vec(logic c, logic l, logic [7:0] lv, logic r, logic m,
                                 logic [7:0] cnt, logic t, logic w, logic d, logic rn);
        vec_t x;
        x.clear = c; x.load = l; x.lv = lv; x.run = r; x.mode = m;
        x.cnt = cnt; x.tick = t; x.wrap = w; x.done = d; x.running = rn;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_val = 0; m_acc = 0; m_snap = 0;
        m_go = 0; m_hold = 0; m_fin = 0; m_down = 0; m_frz = 0;
        m_tick = 0; m_wrap = 0; m_done = 0;
    endtask

    task automatic model_step();
        m_tick = 0; m_wrap = 0; m_done = 0;
        if (bus.clear || bus.load) begin
            m_val = bus.clear ? 0 : clamp_val(bus.load_val);
            m_acc = 0; m_go = 0; m_hold = 0; m_fin = 0; m_frz = 0;
        end else begin
`ifdef LAP_HOLD_EN
            if (bus.lap && (m_go || m_hold)) begin
                if (!m_frz) m_snap = m_val;
                m_frz = !m_frz;
            end
`endif
            if (m_fin) begin
            end else if (m_go) begin
                if (!bus.run) begin
                    m_go = 0; m_hold = 1;
                end else begin
                    m_acc++;
                    if (m_acc == TD) begin
                        m_acc = 0;
                        m_tick = 1;
                        if (m_down) begin
                            m_val--;
                            if (m_val == 0) begin
                                m_done = 1; m_fin = 1; m_go = 0; m_frz = 0;
                            end
                        end else begin
                            m_wrap = m_val == MOD - 1;
                            m_val = (m_val + 1) % MOD;
                        end
                    end
                end
            end else if (m_hold) begin
                if (bus.run) begin
                    m_go = 1; m_hold = 0;
                end
            end else if (bus.run && !(bus.mode && m_val == 0)) begin
                m_go = 1; m_down = bus.mode;
            end
        end
    endtask

    task automatic check_model();
        chk("count", 32'(bus.count_bcd), 32'(to_bcd(m_val)));
        chk("hex", 32'(bus.hex), 32'(to_hex(m_frz ? m_snap : m_val)));
        chk("tick", 32'(bus.tick), 32'(m_tick));
        chk("wrap", 32'(bus.wrap), 32'(m_wrap));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("running", 32'(bus.running), 32'(m_go));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1 check_model();
    endtask

    task automatic drive(logic c, logic l, logic [7:0] lv, logic r, logic m, logic lp);
        bus.clear = c; bus.load = l; bus.load_val = lv; bus.run = r; bus.mode = m; bus.lap = lp;
    endtask

    task automatic wait_tick(input int budget);
        int k = 0;
        do begin
            cycle();
            k++;
        end while (!bus.tick && k < budget);
        chk("tick_within_budget", 32'(bus.tick), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [12];
        logic [7:0] held;
        tbl[0]  = vec(0, 1, 8'h98, 0, 0, 8'h98, 0, 0, 0, 0);
        tbl[1]  = vec(0, 0, 8'h00, 1, 0, 8'h98, 0, 0, 0, 1);
        tbl[2]  = vec(0, 0, 8'h00, 1, 0, 8'h98, 0, 0, 0, 1);
        tbl[3]  = vec(0, 0, 8'h00, 1, 0, 8'h98, 0, 0, 0, 1);
        tbl[4]  = vec(0, 0, 8'h00, 1, 0, 8'h98, 0, 0, 0, 1);
        tbl[5]  = vec(0, 0, 8'h00, 1, 0, 8'h99, 1, 0, 0, 1);
        tbl[6]  = vec(0, 0, 8'h00, 1, 1, 8'h99, 0, 0, 0, 1);
        tbl[7]  = vec(0, 0, 8'h00, 1, 0, 8'h99, 0, 0, 0, 1);
        tbl[8]  = vec(0, 0, 8'h00, 1, 0, 8'h99, 0, 0, 0, 1);
        tbl[9]  = vec(0, 0, 8'h00, 1, 0, 8'h00, 1, 1, 0, 1);
        tbl[10] = vec(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 1);
        tbl[11] = vec(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);

        drive(0, 0, 8'h00, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(bus.count_bcd), 32'h00);
        chk("reset_hex", 32'(bus.hex), 32'h2040);
        chk("reset_pulses", 32'({bus.tick, bus.wrap, bus.done}), 32'd0);
        chk("reset_running", 32'(bus.running), 32'd0);
        clr_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].clear, tbl[i].load, tbl[i].lv, tbl[i].run, tbl[i].mode, 0);
            cycle();
            chk($sformatf("vec%0d_count", i), 32'(bus.count_bcd), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_pulses", i), 32'({bus.tick, bus.wrap, bus.done}),
                32'({tbl[i].tick, tbl[i].wrap, tbl[i].done}));
            chk($sformatf("vec%0d_running", i), 32'(bus.running), 32'(tbl[i].running));
        end

        // Down count to zero, then DONE ignores run until a load.
        drive(0, 1, 8'h02, 0, 1, 0); cycle();
        drive(0, 0, 8'h02, 1, 1, 0);
        repeat (4) cycle();
        chk("down_pre", 32'(bus.count_bcd), 32'h02);
        cycle();
        chk("down_01", 32'(bus.count_bcd), 32'h01);
        repeat (4) cycle();
        chk("down_00", 32'(bus.count_bcd), 32'h00);
        chk("down_done", 32'(bus.done), 32'd1);
        chk("down_stopped", 32'(bus.running), 32'd0);
        repeat (6) cycle();
        chk("done_sticky_count", 32'(bus.count_bcd), 32'h00);
        chk("done_sticky_run", 32'(bus.running), 32'd0);
        drive(0, 1, 8'h10, 1, 1, 0); cycle();
        drive(0, 0, 8'h10, 1, 1, 0);
        repeat (4) cycle();
        chk("reload_pre", 32'(bus.count_bcd), 32'h10);
        cycle();
        chk("reload_09", 32'(bus.count_bcd), 32'h09);

        // Pause two cycles after a tick; resume ticks two cycles after run returns.
        drive(0, 1, 8'h00, 0, 0, 0); cycle();
        drive(0, 0, 8'h00, 1, 0, 0);
        wait_tick(10);
        cycle(); cycle();
        held = to_bcd(m_val);
        bus.run = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("pause_hold", 32'(bus.count_bcd), 32'(held));
        end
        bus.run = 1;
        cycle(); chk("resume_t0", 32'(bus.tick), 32'd0);
        cycle(); chk("resume_t1", 32'(bus.tick), 32'd0);
        cycle(); chk("resume_t2", 32'(bus.tick), 32'd1);

        // Pause on the terminal divider value: step deferred to first RUN cycle after resume.
        wait_tick(10);
        repeat (3) cycle();
        bus.run = 0;
        cycle(); chk("pause_terminal_tick", 32'(bus.tick), 32'd0);
        cycle();
        bus.run = 1;
        cycle(); chk("resume_terminal_t0", 32'(bus.tick), 32'd1 - 32'd1);
        cycle(); chk("resume_terminal_t1", 32'(bus.tick), 32'd1);

        // Clear and load coincident with a tick.
        wait_tick(10);
        repeat (3) cycle();
        drive(1, 1, 8'h5F, 1, 0, 0); cycle();
        chk("prio_count", 32'(bus.count_bcd), 32'h00);
        chk("prio_tick", 32'(bus.tick), 32'd0);
        drive(0, 1, 8'h5F, 0, 0, 0); cycle();
        chk("clamp_count", 32'(bus.count_bcd), 32'h59);

`ifdef LAP_HOLD_EN
        drive(0, 1, 8'h12, 0, 0, 0); cycle();
        drive(0, 0, 8'h12, 1, 0, 0); cycle();
        bus.lap = 1; cycle(); bus.lap = 0;
        wait_tick(10); wait_tick(10); wait_tick(10);
        chk("lap_count", 32'(bus.count_bcd), 32'h15);
        chk("lap_hex_frozen", 32'(bus.hex), 32'h3CA4);
        bus.lap = 1; cycle(); bus.lap = 0;
        chk("lap_hex_live", 32'(bus.hex), 32'h3C92);
`endif

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0, 8'($urandom),
                  $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0);
            cycle();
        end

        // Asynchronous reset mid-count, away from any clock edge.
        drive(0, 1, 8'h47, 0, 0, 0); cycle();
        drive(0, 0, 8'h47, 1, 0, 0);
        repeat (6) cycle();
        #2 clr_n = 1'b0;
        #1;
        chk("async_count", 32'(bus.count_bcd), 32'h00);
        chk("async_hex", 32'(bus.hex), 32'h2040);
        chk("async_running", 32'(bus.running), 32'd0);
        model_reset();
        @(negedge clk);
        clr_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0, 8'($urandom),
                  $urandom_range(0, 4) != 0, 1'($urandom), $urandom_range(0, 7) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
